// File: rtl/instr_register_alu_pipe_pkg.sv
// Shared types and defaults for the instruction register with ALU write pipeline.
// alu_ref gives the expected result for a bench; it follows INSTR_REG_DIV_EN for DIV/MOD.
package instr_register_pkg;

    localparam int DEPTH_DEF = 32;
    localparam int OP_W_DEF  = 32;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    function automatic logic signed [2*OP_W_DEF-1:0] alu_ref(
        input opcode_t                      opc,
        input logic signed [OP_W_DEF-1:0]   a,
        input logic signed [OP_W_DEF-1:0]   b
    );
        logic signed [2*OP_W_DEF-1:0] ae;
        logic signed [2*OP_W_DEF-1:0] be;
        logic signed [2*OP_W_DEF-1:0] r;
        ae = {{OP_W_DEF{a[OP_W_DEF-1]}}, a};
        be = {{OP_W_DEF{b[OP_W_DEF-1]}}, b};
        r  = '0;
        case (opc)
            PASSA:   r = ae;
            PASSB:   r = be;
            ADD:     r = ae + be;
            SUB:     r = ae - be;
            MULT:    r = ae * be;
`ifdef INSTR_REG_DIV_EN
            DIV:     r = (be == '0) ? '0 : ae / be;
            MOD:     r = (be == '0) ? '0 : ae % be;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_register_alu_pipe_if.sv
// Bus between the lab driver and instr_register_alu_pipe: write port, read port, status.
interface instr_register_alu_pipe_if #(
    parameter int DEPTH = 32,
    parameter int OP_W  = 32
);
    localparam int AW    = $clog2(DEPTH);
    localparam int RES_W = 2 * OP_W;
    localparam int IW_W  = 3 + 2 * OP_W + RES_W;

    logic                   load_en;
    logic [AW-1:0]          write_pointer;
    logic [2:0]             opcode;
    logic signed [OP_W-1:0] operand_a;
    logic signed [OP_W-1:0] operand_b;
    logic                   rd_en;
    logic [AW-1:0]          read_pointer;
    logic                   rd_valid;
    logic                   rd_miss;
    logic [IW_W-1:0]        instruction_word;
    logic [AW:0]            valid_count;

    modport master (
        output load_en, write_pointer, opcode, operand_a, operand_b, rd_en, read_pointer,
        input  rd_valid, rd_miss, instruction_word, valid_count
    );

    modport slave (
        input  load_en, write_pointer, opcode, operand_a, operand_b, rd_en, read_pointer,
        output rd_valid, rd_miss, instruction_word, valid_count
    );

endinterface

// File: rtl/instr_register_alu_pipe_alu.sv
// Combinational signed ALU; operands are sign-extended to RES_W first.
// DIV/MOD hardware exists only when INSTR_REG_DIV_EN is defined, otherwise they return 0.
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int OP_W  = 32,
    parameter int RES_W = 2 * OP_W
) (
    input  opcode_t                 opc,
    input  logic signed [OP_W-1:0]  op_a,
    input  logic signed [OP_W-1:0]  op_b,
    output logic signed [RES_W-1:0] result
);

    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;

    assign a_ext = {{(RES_W-OP_W){op_a[OP_W-1]}}, op_a};
    assign b_ext = {{(RES_W-OP_W){op_b[OP_W-1]}}, op_b};

    always_comb begin
        result = '0;
        case (opc)
            ZERO:    result = '0;
            PASSA:   result = a_ext;
            PASSB:   result = b_ext;
            ADD:     result = a_ext + b_ext;
            SUB:     result = a_ext - b_ext;
            MULT:    result = a_ext * b_ext;
`ifdef INSTR_REG_DIV_EN
            // SV signed / and % already truncate toward zero; only b==0 needs guarding
            DIV:     result = (b_ext == '0) ? '0 : a_ext / b_ext;
            MOD:     result = (b_ext == '0) ? '0 : a_ext % b_ext;
`endif
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_register_alu_pipe.sv
// DEPTH-entry instruction register fed by a two-stage ALU write pipeline (S1 -> S2 -> commit).
// Reads forward from S1, then S2, then the array. DIV/MOD depend on INSTR_REG_DIV_EN (see instr_alu).
module instr_register_alu_pipe
    import instr_register_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int OP_W  = OP_W_DEF
) (
    input logic                      clk,
    input logic                      reset_n,
    instr_register_alu_pipe_if.slave bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int RES_W = 2 * OP_W;
    localparam int IW_W  = 3 + 2 * OP_W + RES_W;

    logic                    s1_vld;
    opcode_t                 s1_opc;
    logic signed [OP_W-1:0]  s1_a;
    logic signed [OP_W-1:0]  s1_b;
    logic [AW-1:0]           s1_wp;
    logic signed [RES_W-1:0] s1_res;
    logic [IW_W-1:0]         s1_word;

    logic                    s2_vld;
    logic [AW-1:0]           s2_wp;
    logic [IW_W-1:0]         s2_word;

    logic [IW_W-1:0]         mem [DEPTH];
    logic [DEPTH-1:0]        valid;
    logic [AW:0]             valid_count;

    logic                    wr_in_range;
    logic                    rd_in_range;
    logic                    s1_hit;
    logic                    s2_hit;
    logic                    arr_hit;
    logic                    rd_hit;
    logic [IW_W-1:0]         rd_word;

    logic                    rd_valid_q;
    logic                    rd_miss_q;
    logic [IW_W-1:0]         rd_word_q;

    assign wr_in_range = int'(bus.write_pointer) < DEPTH;
    assign rd_in_range = int'(bus.read_pointer) < DEPTH;

    // Out-of-range writes never become valid in S1, so they cannot forward or commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld <= 1'b0;
            s1_opc <= ZERO;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_wp  <= '0;
        end else begin
            s1_vld <= bus.load_en && wr_in_range;
            if (bus.load_en) begin
                s1_opc <= opcode_t'(bus.opcode);
                s1_a   <= bus.operand_a;
                s1_b   <= bus.operand_b;
                s1_wp  <= bus.write_pointer;
            end
        end
    end

    instr_alu #(
        .OP_W  (OP_W),
        .RES_W (RES_W)
    ) u_alu (
        .opc    (s1_opc),
        .op_a   (s1_a),
        .op_b   (s1_b),
        .result (s1_res)
    );

    assign s1_word = {s1_opc, s1_a, s1_b, s1_res};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_vld  <= 1'b0;
            s2_wp   <= '0;
            s2_word <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_wp   <= s1_wp;
                s2_word <= s1_word;
            end
        end
    end

    // Array contents are deliberately not reset; the valid bits gate every read
    always_ff @(posedge clk) begin
        if (s2_vld) begin
            mem[s2_wp] <= s2_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid       <= '0;
            valid_count <= '0;
        end else if (s2_vld) begin
            valid[s2_wp] <= 1'b1;
            if (!valid[s2_wp]) begin
                valid_count <= valid_count + (AW+1)'(1);
            end
        end
    end

    always_comb begin
        s1_hit  = s1_vld && (s1_wp == bus.read_pointer);
        s2_hit  = s2_vld && (s2_wp == bus.read_pointer);
        arr_hit = rd_in_range && valid[bus.read_pointer];
        rd_hit  = s1_hit || s2_hit || arr_hit;
        rd_word = '0;
        if (s1_hit) begin
            rd_word = s1_word;
        end else if (s2_hit) begin
            rd_word = s2_word;
        end else if (arr_hit) begin
            rd_word = mem[bus.read_pointer];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_miss_q  <= 1'b0;
            rd_word_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_miss_q <= !rd_hit;
                rd_word_q <= rd_word;
            end
        end
    end

    assign bus.rd_valid         = rd_valid_q;
    assign bus.rd_miss          = rd_miss_q;
    assign bus.instruction_word = rd_word_q;
    assign bus.valid_count      = valid_count;

endmodule
